// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, A_LO, A_HI, B_XFER} state_e;
  typedef enum logic {GNT_A, GNT_B} grant_e;
  localparam logic [1:0] DS_BOTH     = 2'b11;
  localparam int         TIMEOUT_DEF = 4095;
endpackage

// File: rtl/sdram_arb_watchdog.sv
// Stall counter for an outstanding downstream transfer, with a sticky timeout flag.
module sdram_arb_watchdog import sdram_arb_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  output logic fire,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // fire lands on the TIMEOUT-th consecutive busy cycle
  assign fire = busy && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (!busy || fire) cnt <= '0;
      else               cnt <= cnt + 1'b1;
      if (fire) timeout <= 1'b1;
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one 16-bit toggle SDRAM port between a 32-bit bus (A) and a
// 16-bit toggle requester (B). Optional stall watchdog: SDRAM_ARB_WATCHDOG_EN.
module sdram_port_arbiter import sdram_arb_pkg::*; #(
  parameter int MEM_AW  = 22,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rv_valid,
  input  logic [22:0]       rv_addr,
  input  logic [31:0]       rv_wdata,
  input  logic [3:0]        rv_wstrb,
  output logic [31:0]       rv_rdata,
  output logic              rv_ready,
  input  logic              b_req,
  output logic              b_ack,
  input  logic [MEM_AW-1:0] b_addr,
  input  logic              b_we,
  input  logic [1:0]        b_ds,
  input  logic [15:0]       b_din,
  output logic [15:0]       b_dout,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_ds,
  output logic [15:0]       mem_din,
  input  logic [15:0]       mem_dout,
  output logic              o_timeout
);
  state_e      state;
  grant_e      last_grant;
  logic        rv_valid_r, a_pend, hi_go;
  logic [20:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;

  logic a_edge, a_req, b_pend, grant_a, grant_b, a_we, rv_we;
  logic busy, done, fire, xfer_end;
  logic [15:0] xdata;
  logic unused_bits;

  assign unused_bits = ^rv_addr[1:0];
  assign a_edge  = rv_valid & ~rv_valid_r;
  assign a_req   = a_pend | a_edge;
  assign b_pend  = b_req ^ b_ack;
  assign grant_a = a_req  & (~b_pend | (last_grant == GNT_B));
  assign grant_b = b_pend & (~a_req  | (last_grant == GNT_A));
  assign a_we    = |a_wstrb;
  assign rv_we   = |rv_wstrb;

  // hi_go marks the one idle cycle between A_LO completion and the A_HI toggle
  assign busy     = (state != IDLE) && !hi_go && (mem_req != mem_ack);
  assign done     = (state != IDLE) && !hi_go && (mem_req == mem_ack);
  assign xfer_end = done | fire;
  assign xdata    = fire ? 16'h0000 : mem_dout;

`ifdef SDRAM_ARB_WATCHDOG_EN
  sdram_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk), .reset(reset), .busy(busy), .fire(fire), .timeout(o_timeout)
  );
`else
  logic unused_wdog;
  assign unused_wdog = busy ^ (TIMEOUT != 0);
  assign fire        = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GNT_B;
      a_pend     <= 1'b0;
      rv_valid_r <= 1'b0;
      hi_go      <= 1'b0;
      a_addr     <= '0;
      a_wdata    <= '0;
      a_wstrb    <= '0;
      rv_ready   <= 1'b0;
      rv_rdata   <= '0;
      b_ack      <= 1'b0;
      b_dout     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_ds     <= '0;
      mem_din    <= '0;
    end else begin
      rv_valid_r <= rv_valid;
      rv_ready   <= 1'b0;
      a_pend     <= a_pend | a_edge;
      if (fire) mem_req <= mem_ack;
      unique case (state)
        IDLE: begin
          if (grant_a) begin
            a_pend     <= 1'b0;
            last_grant <= GNT_A;
            a_addr     <= rv_addr[22:2];
            a_wdata    <= rv_wdata;
            a_wstrb    <= rv_wstrb;
            mem_we     <= rv_we;
            mem_req    <= ~mem_req;
            if (rv_we && rv_wstrb[1:0] == 2'b00) begin
              state    <= A_HI;
              mem_addr <= MEM_AW'({rv_addr[22:2], 1'b1});
              mem_ds   <= rv_wstrb[3:2];
              mem_din  <= rv_wdata[31:16];
            end else begin
              state    <= A_LO;
              mem_addr <= MEM_AW'({rv_addr[22:2], 1'b0});
              mem_ds   <= rv_we ? rv_wstrb[1:0] : DS_BOTH;
              mem_din  <= rv_wdata[15:0];
            end
          end else if (grant_b) begin
            last_grant <= GNT_B;
            state      <= B_XFER;
            mem_addr   <= b_addr;
            mem_we     <= b_we;
            mem_ds     <= b_ds;
            mem_din    <= b_din;
            mem_req    <= ~mem_req;
          end
        end
        A_LO: begin
          if (xfer_end) begin
            if (!a_we) rv_rdata[15:0] <= xdata;
            if (a_we && a_wstrb[3:2] == 2'b00) begin
              rv_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              state    <= A_HI;
              hi_go    <= 1'b1;
              mem_addr <= MEM_AW'({a_addr, 1'b1});
              mem_ds   <= a_we ? a_wstrb[3:2] : DS_BOTH;
              mem_din  <= a_wdata[31:16];
            end
          end
        end
        A_HI: begin
          if (hi_go) begin
            hi_go   <= 1'b0;
            mem_req <= ~mem_req;
          end else if (xfer_end) begin
            if (!a_we) rv_rdata[31:16] <= xdata;
            rv_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        B_XFER: begin
          if (xfer_end) begin
            b_dout <= xdata;
            b_ack  <= b_req;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
